instr_encoder: RTL and testbench
================================

# instr_encoder

Encodes RV32I R-type and I-type ALU instructions from field-level commands (using the `cpu_pkg` ALU op enum) into 32-bit instruction words. It writes them sequentially into instruction memory. It is the inverse of the instruction decoder and is used by the program loader and by test benches to build programs without hand-assembled hex. A start/run/done/error FSM drives it, with a registered memory-write stage and a word counter with overflow detection.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first word written.
- `DEPTH`, default 1024: maximum number of words per program. Must be ≥1.
- `clk` input, 1: clock, rising edge.
- `rst` input, 1: reset, asynchronous, active-high.
- `start` input, 1: single-cycle pulse that begins a program.
- `cmd_valid` input, 1: command present.
- `cmd_ready` output, 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_is_imm` input, 1: 0 = R-type (opcode 0110011), 1 = I-type (opcode 0010011).
- `cmd_alu_op` input, `t_alu_op`: ALU operation from `cpu_pkg`.
- `cmd_rd`, `cmd_rs1`, `cmd_rs2` input, 5 each: register fields. `cmd_rs2` is ignored for I-type.
- `cmd_imm` input, 32: signed immediate. Ignored for R-type.
- `cmd_last` input, 1: final command of the program.
- `imem_wr_en` output, 1: instruction memory write strobe.
- `imem_wr_addr` output, 32: byte address, word aligned.
- `imem_wr_data` output, 32: encoded instruction.
- `busy` output, 1: FSM is in RUN.
- `done` output, 1: FSM is in DONE (level).
- `err` output, 1: FSM is in ERR (level).
- `err_code` output, 2: 00 none, 01 illegal op, 10 immediate out of range, 11 overflow.
- `word_count` output, $clog2(DEPTH+1): words written since the last start.

## Operation
- FSM states are IDLE, RUN, DONE and ERR.
  - IDLE→RUN on `start`.
  - DONE→RUN and ERR→RUN on `start`. Entering RUN clears the address to `BASE_ADDR`, clears `word_count` to 0 and clears `err_code` to 00.
  - `start` while in RUN is ignored.
- `cmd_ready` = 1 only in RUN.
- Field placement for every accepted command: `rd`→[11:7], `rs1`→[19:15], funct3→[14:12], opcode→[6:0].
- R-type encoding (`rs2`→[24:20], funct7→[31:25]):
  - ADD: 000 / 0000000
  - SUB: 000 / 0100000
  - SLL: 001
  - SLT: 010
  - SLTU: 011
  - XOR: 100
  - SRL: 101 / 0000000
  - SRA: 101 / 0100000
  - OR: 110
  - AND: 111
  - All funct7 fields not listed above are 0000000.
- I-type encoding:
  - ADD/SLT/SLTU/XOR/OR/AND map to ADDI/SLTI/SLTIU/XORI/ORI/ANDI, with `imm[11:0]`→[31:20].
  - The immediate must satisfy −2048 ≤ `cmd_imm` ≤ 2047 as signed 32-bit; otherwise error 10.
  - SLL/SRL/SRA map to SLLI/SRLI/SRAI, with shamt `cmd_imm[4:0]`→[24:20] and [31:25] = 0000000, or 0100000 for SRAI.
  - The shamt must satisfy 0 ≤ `cmd_imm` ≤ 31; otherwise error 10.
  - SUB with `cmd_is_imm`=1 is error 01.
- Any `t_alu_op` value not listed is error 01.
- Overflow: a command accepted while `word_count` == `DEPTH` is error 11.
- Error priority: 11 > 01 > 10.
- On any error: no write, state goes to ERR, and `err_code` is latched and held until `start` or `rst`.
- On a valid command: write issued, address += 4, `word_count` += 1.
  - If `cmd_last` = 1, state goes to DONE.
  - A `cmd_last` with an error goes to ERR, not DONE.

## Timing
- Reset values: state IDLE, `cmd_ready`=0, `imem_wr_en`=0, `imem_wr_addr`=`BASE_ADDR`, `imem_wr_data`=0, `busy`=0, `done`=0, `err`=0, `err_code`=00, `word_count`=0.
- `start` at edge N means state is RUN and `cmd_ready`=1 from cycle N+1. Commands presented in cycle N are not accepted.
- A command accepted in cycle N produces `imem_wr_en`=1 with address and data in cycle N+1, for exactly one cycle. `word_count` updates in N+1.
- Throughput is one command per cycle with no bubbles. `imem_wr_en` is 0 in any cycle after which nothing was accepted.
- A `cmd_last` or error accepted in cycle N means the state is DONE or ERR in N+1. `cmd_ready`=0 from N+1. The final write (if valid) still occurs in N+1.
- `imem_wr_addr` holds its last value when no write occurs.
- `rst` mid-program: everything returns to reset values immediately. A pending write is dropped.

## Test plan
- `start`, then ADD x3,x1,x2 (last) → one write in cycle after accept: addr 0x0, data 0x002081B3; `done`=1, `word_count`=1.
- Back-to-back SUB x5,x6,x7; ADDI x1,x0,−1; SRAI x2,x2,3 (last) → consecutive writes at 0x0/0x4/0x8 with 0x407302B3, 0xFFF00093, 0x40315113; no gap cycles.
- ADDI with imm 2048 → no write, `err`=1, `err_code`=10; SLLI with imm 32 → `err_code`=10; SUB with `cmd_is_imm`=1 → `err_code`=01.
- `DEPTH`=4, five commands without last → four writes, fifth gives `err_code`=11, `word_count`=4; `start` again → address back to `BASE_ADDR`, `err`=0.
- `rst` asserted the cycle after an accept → no `imem_wr_en`, all outputs at reset values; `cmd_valid` with no `start` → `cmd_ready` stays 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: the ALU operation enum used by the decoder, ALU and instruction encoder.
package cpu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_COPY_A,
    ALU_COPY_B,
    ALU_LUI,
    ALU_MUL,
    ALU_MULH,
    ALU_DIV
  } t_alu_op;

endpackage

// File: rtl/instr_encoder_if.sv
// Command channel into the instruction encoder and the instruction-memory write bus out of it.
interface instr_encoder_if;

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_is_imm;
  cpu_pkg::t_alu_op cmd_alu_op;
  logic [4:0]       cmd_rd;
  logic [4:0]       cmd_rs1;
  logic [4:0]       cmd_rs2;
  logic [31:0]      cmd_imm;
  logic             cmd_last;
  logic             imem_wr_en;
  logic [31:0]      imem_wr_addr;
  logic [31:0]      imem_wr_data;

  modport master (
    output cmd_valid, cmd_is_imm, cmd_alu_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, cmd_last,
    input  cmd_ready, imem_wr_en, imem_wr_addr, imem_wr_data
  );

  modport slave (
    input  cmd_valid, cmd_is_imm, cmd_alu_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, cmd_last,
    output cmd_ready, imem_wr_en, imem_wr_addr, imem_wr_data
  );

endinterface

// File: rtl/instr_encoder.sv
// Encodes RV32I R-type / I-type ALU commands into instruction words and writes them
// sequentially into instruction memory, under an IDLE/RUN/DONE/ERR program FSM.
module instr_encoder
  import cpu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  instr_encoder_if.slave               bus,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [1:0]                   err_code,
  output logic [$clog2(DEPTH+1)-1:0]   word_count
);

  localparam int CW = $clog2(DEPTH+1);

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} t_state;

  typedef enum logic [1:0] {
    E_NONE = 2'b00,
    E_OP   = 2'b01,
    E_IMM  = 2'b10,
    E_OVF  = 2'b11
  } t_err;

  t_state      state_q, state_d;
  t_err        err_q;
  t_err        enc_err;
  logic [31:0] enc_word;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        op_legal;
  logic        is_shift;
  logic        imm_ok;
  logic        accept;
  logic        restart;

  assign accept  = bus.cmd_valid && (state_q == S_RUN);
  assign restart = start && (state_q != S_RUN);

  // Field encoding and error classification of the command currently on the bus.
  // NOTE: every signal driven here gets a default first, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    funct3   = 3'b000;
    funct7   = 7'b0000000;
    op_legal = 1'b1;
    is_shift = 1'b0;
    case (bus.cmd_alu_op)
      ALU_ADD:  funct3 = 3'b000;
      ALU_SUB:  begin funct3 = 3'b000; funct7 = 7'b0100000; op_legal = !bus.cmd_is_imm; end
      ALU_SLL:  begin funct3 = 3'b001; is_shift = 1'b1; end
      ALU_SLT:  funct3 = 3'b010;
      ALU_SLTU: funct3 = 3'b011;
      ALU_XOR:  funct3 = 3'b100;
      ALU_SRL:  begin funct3 = 3'b101; is_shift = 1'b1; end
      ALU_SRA:  begin funct3 = 3'b101; funct7 = 7'b0100000; is_shift = 1'b1; end
      ALU_OR:   funct3 = 3'b110;
      ALU_AND:  funct3 = 3'b111;
      default:  op_legal = 1'b0;
    endcase

    // Unsigned compare also rejects negative shift amounts.
    if (is_shift) imm_ok = (bus.cmd_imm <= 32'd31);
    else          imm_ok = ($signed(bus.cmd_imm) >= -32'sd2048) && ($signed(bus.cmd_imm) <= 32'sd2047);

    if (!bus.cmd_is_imm)
      enc_word = {funct7, bus.cmd_rs2, bus.cmd_rs1, funct3, bus.cmd_rd, OPC_R};
    else if (is_shift)
      enc_word = {funct7, bus.cmd_imm[4:0], bus.cmd_rs1, funct3, bus.cmd_rd, OPC_I};
    else
      enc_word = {bus.cmd_imm[11:0], bus.cmd_rs1, funct3, bus.cmd_rd, OPC_I};

    if (word_count == CW'(DEPTH))        enc_err = E_OVF;
    else if (!op_legal)                  enc_err = E_OP;
    else if (bus.cmd_is_imm && !imm_ok)  enc_err = E_IMM;
    else                                 enc_err = E_NONE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start) state_d = S_RUN;
      S_RUN: begin
        if (accept) begin
          if (enc_err != E_NONE) state_d = S_ERR;
          else if (bus.cmd_last) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered write stage; the write address is derived from the pre-increment count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.imem_wr_en   <= 1'b0;
      bus.imem_wr_addr <= BASE_ADDR;
      bus.imem_wr_data <= 32'h0;
      word_count       <= '0;
      err_q            <= E_NONE;
    end else begin
      bus.imem_wr_en <= 1'b0;
      if (restart) begin
        bus.imem_wr_addr <= BASE_ADDR;
        word_count       <= '0;
        err_q            <= E_NONE;
      end else if (accept) begin
        if (enc_err == E_NONE) begin
          bus.imem_wr_en   <= 1'b1;
          bus.imem_wr_addr <= BASE_ADDR + (32'(word_count) << 2);
          bus.imem_wr_data <= enc_word;
          word_count       <= word_count + CW'(1);
        end else begin
          err_q <= enc_err;
        end
      end
    end
  end

  assign busy          = (state_q == S_RUN);
  assign done          = (state_q == S_DONE);
  assign err           = (state_q == S_ERR);
  assign err_code      = err_q;
  assign bus.cmd_ready = busy;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: vector table, directed multi-cycle sequences
// and randomized programs checked against a field-level reference encoder.
module tb_instr_encoder;
  import cpu_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          DEPTH = 4;
  localparam int          CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, err;
  logic [1:0]    err_code;
  logic [CW-1:0] word_count;

  instr_encoder_if bus();

  instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        is_imm;
    t_alu_op     op;
    int          rd, rs1, rs2;
    logic [31:0] imm;
    logic [31:0] word;
    int          code;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: assemble the instruction from the ISA field table with plain arithmetic.
  function automatic void ref_encode(input logic is_imm, input t_alu_op op, input int rd,
                                     input int rs1, input int rs2, input logic [31:0] imm,
                                     input int count, output int code, output logic [31:0] word);
    int     f3, f7;
    bit     known, shift;
    longint simm, w;
    known = 1; shift = 0; f3 = 0; f7 = 0;
    case (op)
      ALU_ADD:  f3 = 0;
      ALU_SUB:  begin f3 = 0; f7 = 32; end
      ALU_SLL:  begin f3 = 1; shift = 1; end
      ALU_SLT:  f3 = 2;
      ALU_SLTU: f3 = 3;
      ALU_XOR:  f3 = 4;
      ALU_SRL:  begin f3 = 5; shift = 1; end
      ALU_SRA:  begin f3 = 5; f7 = 32; shift = 1; end
      ALU_OR:   f3 = 6;
      ALU_AND:  f3 = 7;
      default:  known = 0;
    endcase
    simm = longint'($signed(imm));
    if (count >= DEPTH)                       code = 3;
    else if (!known || (is_imm && op == ALU_SUB)) code = 1;
    else if (is_imm && (shift ? (simm < 0 || simm > 31) : (simm < -2048 || simm > 2047))) code = 2;
    else                                      code = 0;
    w = rs1 * 2**15 + f3 * 2**12 + rd * 2**7;
    if (!is_imm)    w += f7 * 2**25 + rs2 * 2**20 + 'h33;
    else if (shift) w += f7 * 2**25 + (simm & 31) * 2**20 + 'h13;
    else            w += (simm & 'hFFF) * 2**20 + 'h13;
    word = w[31:0];
  endfunction

  task automatic drive(input logic is_imm, input t_alu_op op, input int rd, input int rs1,
                       input int rs2, input logic [31:0] imm, input logic last);
    bus.cmd_valid  = 1'b1;
    bus.cmd_is_imm = is_imm;
    bus.cmd_alu_op = op;
    bus.cmd_rd     = 5'(rd);
    bus.cmd_rs1    = 5'(rs1);
    bus.cmd_rs2    = 5'(rs2);
    bus.cmd_imm    = imm;
    bus.cmd_last   = last;
  endtask

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  function automatic logic [31:0] pick_imm();
    case ($urandom_range(0, 9))
      0: return 32'(2047);
      1: return 32'(2048);
      2: return -32'sd2048;
      3: return -32'sd2049;
      4: return 32'(31);
      5: return 32'(32);
      6: return 32'($urandom);
      7: return -32'($urandom_range(1, 40));
      default: return 32'($urandom_range(0, 40));
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          code;
    logic [31:0] word;

    rst = 1'b1; start = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_is_imm = 1'b0; bus.cmd_alu_op = ALU_ADD;
    bus.cmd_rd = '0; bus.cmd_rs1 = '0; bus.cmd_rs2 = '0; bus.cmd_imm = '0; bus.cmd_last = 1'b0;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_ready", bus.cmd_ready, 0);
    check("rst_wr_en", bus.imem_wr_en, 0);
    check("rst_addr", bus.imem_wr_addr, BASE);
    check("rst_data", bus.imem_wr_data, 0);
    check("rst_status", {busy, done, err}, 0);
    check("rst_code", err_code, 0);
    check("rst_count", word_count, 0);
    rst = 1'b0;

    // Command without start is never accepted.
    drive(1'b0, ALU_ADD, 3, 1, 2, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("nostart_ready", bus.cmd_ready, 0);
      check("nostart_wr_en", bus.imem_wr_en, 0);
    end
    check("nostart_count", word_count, 0);

    // Back-to-back program; the command present in the start cycle is not taken.
    @(negedge clk);
    start = 1'b1;
    drive(1'b0, ALU_SUB, 5, 6, 7, 0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("startcyc_wr_en", bus.imem_wr_en, 0);
    check("startcyc_count", word_count, 0);
    check("startcyc_ready", bus.cmd_ready, 1);
    @(negedge clk);
    check("b2b0_wr_en", bus.imem_wr_en, 1);
    check("b2b0_addr", bus.imem_wr_addr, 32'h0);
    check("b2b0_data", bus.imem_wr_data, 32'h407302B3);
    drive(1'b1, ALU_ADD, 1, 0, 0, -32'sd1, 1'b0);
    @(negedge clk);
    check("b2b1_wr_en", bus.imem_wr_en, 1);
    check("b2b1_addr", bus.imem_wr_addr, 32'h4);
    check("b2b1_data", bus.imem_wr_data, 32'hFFF00093);
    drive(1'b1, ALU_SRA, 2, 2, 0, 3, 1'b1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("b2b2_wr_en", bus.imem_wr_en, 1);
    check("b2b2_addr", bus.imem_wr_addr, 32'h8);
    check("b2b2_data", bus.imem_wr_data, 32'h40315113);
    check("b2b_done", done, 1);
    check("b2b_count", word_count, 3);
    check("b2b_ready", bus.cmd_ready, 0);
    @(negedge clk);
    check("b2b_idle_wr_en", bus.imem_wr_en, 0);
    check("b2b_addr_hold", bus.imem_wr_addr, 32'h8);

    // Single-command programs from the vector table.
    vecs.push_back('{1'b0, ALU_ADD,  3,  1,  2,  32'd0,     32'h002081B3, 0});
    vecs.push_back('{1'b0, ALU_SUB,  5,  6,  7,  32'd0,     32'h407302B3, 0});
    vecs.push_back('{1'b1, ALU_ADD,  1,  0,  0, -32'sd1,    32'hFFF00093, 0});
    vecs.push_back('{1'b1, ALU_SRA,  2,  2,  0,  32'd3,     32'h40315113, 0});
    vecs.push_back('{1'b0, ALU_XOR, 10, 11, 12,  32'd999,   32'h00C5C533, 0});
    vecs.push_back('{1'b0, ALU_SRA,  4,  5,  6,  32'd0,     32'h4062D233, 0});
    vecs.push_back('{1'b1, ALU_ADD,  1,  0,  0, -32'sd2048, 32'h80000093, 0});
    vecs.push_back('{1'b1, ALU_ADD,  1,  0,  0,  32'd2047,  32'h7FF00093, 0});
    vecs.push_back('{1'b1, ALU_SLL,  1,  1,  0,  32'd31,    32'h01F09093, 0});
    vecs.push_back('{1'b1, ALU_SLTU, 7,  8,  0,  32'd100,   32'h06443393, 0});
    vecs.push_back('{1'b1, ALU_ADD,  1,  0,  0,  32'd2048,  32'h0, 2});
    vecs.push_back('{1'b1, ALU_ADD,  1,  0,  0, -32'sd2049, 32'h0, 2});
    vecs.push_back('{1'b1, ALU_SLL,  1,  1,  0,  32'd32,    32'h0, 2});
    vecs.push_back('{1'b1, ALU_SRL,  1,  1,  0, -32'sd1,    32'h0, 2});
    vecs.push_back('{1'b1, ALU_SUB,  1,  1,  0,  32'd5,     32'h0, 1});
    vecs.push_back('{1'b1, ALU_SUB,  1,  1,  0,  32'd5000,  32'h0, 1});
    vecs.push_back('{1'b0, ALU_MUL,  1,  2,  3,  32'd0,     32'h0, 1});

    foreach (vecs[k]) begin
      do_start();
      check($sformatf("v%0d_ready", k), bus.cmd_ready, 1);
      check($sformatf("v%0d_count0", k), word_count, 0);
      drive(vecs[k].is_imm, vecs[k].op, vecs[k].rd, vecs[k].rs1, vecs[k].rs2, vecs[k].imm, 1'b1);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      check($sformatf("v%0d_wr_en", k), bus.imem_wr_en, vecs[k].code == 0);
      if (vecs[k].code == 0) begin
        check($sformatf("v%0d_addr", k), bus.imem_wr_addr, BASE);
        check($sformatf("v%0d_data", k), bus.imem_wr_data, vecs[k].word);
      end
      check($sformatf("v%0d_done", k), done, vecs[k].code == 0);
      check($sformatf("v%0d_err", k), err, vecs[k].code != 0);
      check($sformatf("v%0d_code", k), err_code, vecs[k].code);
      check($sformatf("v%0d_count", k), word_count, vecs[k].code == 0);
      check($sformatf("v%0d_ready_off", k), bus.cmd_ready, 0);
    end

    // Overflow: DEPTH writes, then the next command is rejected with code 11.
    do_start();
    for (int k = 0; k <= DEPTH; k++) begin
      drive(1'b0, ALU_ADD, 1, 1, 1, 0, 1'b0);
      @(negedge clk);
      if (k < DEPTH) begin
        check($sformatf("ovf%0d_wr_en", k), bus.imem_wr_en, 1);
        check($sformatf("ovf%0d_addr", k), bus.imem_wr_addr, BASE + 32'(4 * k));
      end else begin
        check("ovf_wr_en", bus.imem_wr_en, 0);
        check("ovf_err", err, 1);
        check("ovf_code", err_code, 3);
        check("ovf_count", word_count, DEPTH);
      end
    end
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("ovf_code_held", err_code, 3);
    do_start();
    check("restart_addr", bus.imem_wr_addr, BASE);
    check("restart_err", err, 0);
    check("restart_code", err_code, 0);
    check("restart_count", word_count, 0);
    check("restart_busy", busy, 1);

    // start during RUN is ignored.
    drive(1'b0, ALU_ADD, 1, 1, 1, 0, 1'b0);
    @(negedge clk);
    start = 1'b1;
    drive(1'b0, ALU_OR, 2, 2, 2, 0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    bus.cmd_valid = 1'b0;
    ref_encode(1'b0, ALU_OR, 2, 2, 2, 0, 1, code, word);
    check("runstart_addr", bus.imem_wr_addr, BASE + 32'h4);
    check("runstart_data", bus.imem_wr_data, word);
    check("runstart_count", word_count, 2);
    check("runstart_busy", busy, 1);
    drive(1'b0, ALU_AND, 3, 3, 3, 0, 1'b1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("runstart_done", done, 1);
    check("runstart_count3", word_count, 3);

    // Randomized programs against the reference encoder.
    for (int p = 0; p < 60; p++) begin
      int len, count;
      len = $urandom_range(1, 6);
      count = 0;
      do_start();
      for (int i = 0; i < len; i++) begin
        logic        is_imm;
        t_alu_op     op;
        int          rd, rs1, rs2;
        logic [31:0] imm;
        logic        last;
        if ($urandom_range(0, 3) == 0) begin
          bus.cmd_valid = 1'b0;
          @(negedge clk);
          check("rnd_gap_wr_en", bus.imem_wr_en, 0);
        end
        check("rnd_ready", bus.cmd_ready, 1);
        is_imm = 1'($urandom_range(0, 1));
        op     = ($urandom_range(0, 4) == 0) ? t_alu_op'($urandom_range(0, 15))
                                             : t_alu_op'($urandom_range(0, 9));
        rd     = $urandom_range(0, 31);
        rs1    = $urandom_range(0, 31);
        rs2    = $urandom_range(0, 31);
        imm    = pick_imm();
        last   = (i == len - 1);
        ref_encode(is_imm, op, rd, rs1, rs2, imm, count, code, word);
        drive(is_imm, op, rd, rs1, rs2, imm, last);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("rnd_wr_en", bus.imem_wr_en, code == 0);
        if (code == 0) begin
          check("rnd_addr", bus.imem_wr_addr, BASE + 32'(4 * count));
          check("rnd_data", bus.imem_wr_data, word);
          count++;
        end
        check("rnd_count", word_count, count);
        check("rnd_code", err_code, code);
        check("rnd_err", err, code != 0);
        check("rnd_done", done, code == 0 && last);
        if (code != 0) break;
      end
    end

    // rst during the write cycle of an accepted command.
    do_start();
    drive(1'b0, ALU_ADD, 3, 1, 2, 0, 1'b0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("midrst_pre_wr_en", bus.imem_wr_en, 1);
    rst = 1'b1;
    #1;
    check("midrst_wr_en", bus.imem_wr_en, 0);
    check("midrst_addr", bus.imem_wr_addr, BASE);
    check("midrst_data", bus.imem_wr_data, 0);
    check("midrst_status", {busy, done, err}, 0);
    check("midrst_ready", bus.cmd_ready, 0);
    check("midrst_count", word_count, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, ALU_ADD, 3, 1, 2, 0, 1'b0);
    @(negedge clk);
    check("postrst_ready", bus.cmd_ready, 0);
    @(negedge clk);
    check("postrst_wr_en", bus.imem_wr_en, 0);
    bus.cmd_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
